// File: rtl/buff_arbiter.sv
// buff_arbiter: arbitrates ownership of a shared transmit buffer between the
// system and a client, and sequences byte-by-byte transmission of the buffer
// contents to a UART transmitter while the system holds ownership.
module buff_arbiter #(
    parameter int WORDS = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sys_req,
    input  logic             sys_rel,
    input  logic             cli_req,
    input  logic             cli_rel,
    output logic             sys_grant,
    output logic             cli_grant,
    input  logic             tx_go,
    input  logic [5:0]       tx_len,
    output logic [WORDS-1:0] buff_addr,
    output logic             buff_rd,
    output logic             tx_en,
    input  logic             tx_complete,
    output logic             busy,
    output logic             done
);

    // Longest transfer is one full pass over the buffer; when the buffer is
    // deeper than any 6-bit length the clamp never engages.
    localparam logic [6:0] CAP = (WORDS >= 6) ? 7'd127 : 7'(2 ** WORDS);

    typedef enum logic [2:0] {
        IDLE,
        SYS_OWN,
        CLI_OWN,
        TX_FETCH,
        TX_LOAD,
        TX_WAIT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] count;
    logic [6:0] len_clamped;
    logic       tx_accept;
    logic       tx_start;
    logic       tx_empty;
    logic       byte_done;
    logic       last_byte;

    // tx_go only counts while the system owns an idle buffer and is not
    // releasing it in the same cycle; release wins.
    assign tx_accept = (state == SYS_OWN) && !sys_rel && tx_go;
    assign tx_start  = tx_accept && (tx_len != 6'd0);
    assign tx_empty  = tx_accept && (tx_len == 6'd0);
    assign byte_done = (state == TX_WAIT) && tx_complete;
    assign last_byte = byte_done && (count <= 7'd1);

    // Clamp the requested length to one pass over the buffer.
    always_comb begin
        len_clamped = {1'b0, tx_len};
        if (len_clamped > CAP) begin
            len_clamped = CAP;
        end
    end

    // State register; reset returns to IDLE from anywhere, aborting a transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: client wins ties in IDLE, no preemption of an owner.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cli_req) begin
                    state_next = CLI_OWN;
                end else if (sys_req) begin
                    state_next = SYS_OWN;
                end
            end
            SYS_OWN: begin
                if (sys_rel) begin
                    state_next = IDLE;
                end else if (tx_start) begin
                    state_next = TX_FETCH;
                end
            end
            CLI_OWN: begin
                if (cli_rel) begin
                    state_next = IDLE;
                end
            end
            TX_FETCH: state_next = TX_LOAD;
            TX_LOAD:  state_next = TX_WAIT;
            TX_WAIT: begin
                if (byte_done) begin
                    state_next = last_byte ? SYS_OWN : TX_FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state: grants, read strobe, transmitter trigger, busy.
    always_comb begin
        sys_grant = 1'b0;
        cli_grant = 1'b0;
        buff_rd   = 1'b1;
        tx_en     = 1'b1;
        busy      = 1'b0;
        case (state)
            SYS_OWN: sys_grant = 1'b1;
            CLI_OWN: cli_grant = 1'b1;
            TX_FETCH: begin
                sys_grant = 1'b1;
                busy      = 1'b1;
                buff_rd   = 1'b0;
            end
            TX_LOAD: begin
                sys_grant = 1'b1;
                busy      = 1'b1;
                tx_en     = 1'b0;
            end
            TX_WAIT: begin
                sys_grant = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte counter, read address and end-of-transfer pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= 7'd0;
            buff_addr <= '0;
            done      <= 1'b0;
        end else begin
            done <= tx_empty || last_byte;
            if (tx_start) begin
                count     <= len_clamped;
                buff_addr <= '0;
            end else if (byte_done) begin
                count <= count - 7'd1;
                if (!last_byte) begin
                    // Natural wrap modulo the buffer depth.
                    buff_addr <= buff_addr + WORDS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_buff_arbiter.sv
// Testbench for buff_arbiter: a table of single-cycle vectors for arbitration
// and control, followed by hand-written multi-cycle transmission sequences.
module tb_buff_arbiter;

    localparam int W = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         sys_req = 1'b0;
    logic         sys_rel = 1'b0;
    logic         cli_req = 1'b0;
    logic         cli_rel = 1'b0;
    logic         sys_grant;
    logic         cli_grant;
    logic         tx_go = 1'b0;
    logic [5:0]   tx_len = 6'd0;
    logic [W-1:0] buff_addr;
    logic         buff_rd;
    logic         tx_en;
    logic         tx_complete = 1'b0;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_n   = 0;

    buff_arbiter #(.WORDS(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .sys_req     (sys_req),
        .sys_rel     (sys_rel),
        .cli_req     (cli_req),
        .cli_rel     (cli_rel),
        .sys_grant   (sys_grant),
        .cli_grant   (cli_grant),
        .tx_go       (tx_go),
        .tx_len      (tx_len),
        .buff_addr   (buff_addr),
        .buff_rd     (buff_rd),
        .tx_en       (tx_en),
        .tx_complete (tx_complete),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // ins = {reset, sys_req, sys_rel, cli_req, cli_rel, tx_go, tx_complete}
    // exp_out = {sys_grant, cli_grant, busy, done, tx_en, buff_rd}
    typedef struct {
        logic [6:0] ins;
        logic [5:0] len;
        logic [5:0] exp_out;
        logic [4:0] exp_addr;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clock);
        #1;
        tick_n++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({sys_grant, cli_grant, busy, done, tx_en, buff_rd, buff_addr});
    endfunction

    task automatic clear_inputs();
        {reset, sys_req, sys_rel, cli_req, cli_rel, tx_go, tx_complete} = 7'd0;
        tx_len = 6'd0;
    endtask

    task automatic acquire_sys(input string name);
        sys_req = 1'b1;
        tick();
        sys_req = 1'b0;
        check(name, 32'(sys_grant), 32'd1);
    endtask

    // Runs one transfer from SYS_OWN, answering each tx_en with tx_complete
    // five cycles later. Optionally pokes sys_rel and a second tx_go mid-way.
    task automatic run_tx(input string name, input int len, input int exp_n, input bit pokes);
        int  pulses = 0;
        int  dones  = 0;
        int  cd     = 0;
        int  go_t;
        int  cmp_t  = -1;
        bit  fin    = 1'b0;
        bit  grant_ok = 1'b1;
        bit  addr_ok  = 1'b1;
        bit  lat_ok   = 1'b1;
        bit  busy_ok  = 1'b1;
        tx_go  = 1'b1;
        tx_len = 6'(len);
        tick();
        go_t   = tick_n;
        tx_go  = 1'b0;
        tx_len = 6'd0;
        for (int it = 0; it < 3000 && !fin; it++) begin
            tx_complete = 1'b0;
            sys_rel     = pokes && (it == 4);
            tx_go       = pokes && (it == 6);
            tx_len      = (pokes && (it == 6)) ? 6'd7 : 6'd0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_complete = 1'b1;
                    cmp_t = tick_n + 1;
                end
            end
            tick();
            if (sys_grant !== 1'b1) grant_ok = 1'b0;
            if (tx_en === 1'b0) begin
                if (buff_addr !== 5'(pulses)) addr_ok = 1'b0;
                // tx_en follows tx_go / tx_complete by two cycles
                if (pulses == 0) begin
                    if (tick_n - go_t != 1) lat_ok = 1'b0;
                end else if (tick_n - cmp_t != 1) begin
                    lat_ok = 1'b0;
                end
                pulses++;
                cd = 5;
            end
            if (done === 1'b1) begin
                dones++;
                fin = 1'b1;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        clear_inputs();
        check({name, "_done_seen"}, 32'(fin), 32'd1);
        check({name, "_pulses"}, 32'(pulses), 32'(exp_n));
        check({name, "_addr_seq"}, 32'(addr_ok), 32'd1);
        check({name, "_latency"}, 32'(lat_ok), 32'd1);
        check({name, "_grant_held"}, 32'(grant_ok), 32'd1);
        check({name, "_busy"}, 32'(busy_ok), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check({name, "_done_once"}, 32'(dones), 32'd1);
        check({name, "_back_sys_own"}, outs(), 32'({6'b100011, buff_addr}));
    endtask

    initial begin
        vecs[0]  = '{7'b1000000, 6'd0, 6'b000011, 5'd0};
        vecs[1]  = '{7'b0000000, 6'd0, 6'b000011, 5'd0};
        vecs[2]  = '{7'b0101000, 6'd0, 6'b010011, 5'd0};
        vecs[3]  = '{7'b0101000, 6'd0, 6'b010011, 5'd0};
        vecs[4]  = '{7'b0100010, 6'd3, 6'b010011, 5'd0};
        vecs[5]  = '{7'b0100100, 6'd0, 6'b000011, 5'd0};
        vecs[6]  = '{7'b0100000, 6'd0, 6'b100011, 5'd0};
        vecs[7]  = '{7'b0001000, 6'd0, 6'b100011, 5'd0};
        vecs[8]  = '{7'b0001010, 6'd0, 6'b100111, 5'd0};
        vecs[9]  = '{7'b0001000, 6'd0, 6'b100011, 5'd0};
        vecs[10] = '{7'b0001010, 6'd1, 6'b101010, 5'd0};
        vecs[11] = '{7'b0011000, 6'd0, 6'b101001, 5'd0};
        vecs[12] = '{7'b0001000, 6'd0, 6'b101011, 5'd0};
        vecs[13] = '{7'b0001001, 6'd0, 6'b100111, 5'd0};
        vecs[14] = '{7'b0011000, 6'd0, 6'b000011, 5'd0};
        vecs[15] = '{7'b0001000, 6'd0, 6'b010011, 5'd0};
        vecs[16] = '{7'b0000100, 6'd0, 6'b000011, 5'd0};
        vecs[17] = '{7'b0000001, 6'd0, 6'b000011, 5'd0};

        for (int i = 0; i < 18; i++) begin
            {reset, sys_req, sys_rel, cli_req, cli_rel, tx_go, tx_complete} = vecs[i].ins;
            tx_len = vecs[i].len;
            tick();
            check($sformatf("vec%0d", i), outs(), 32'({vecs[i].exp_out, vecs[i].exp_addr}));
        end
        clear_inputs();

        // Three-byte transfer with sys_rel and tx_go poked mid-transfer.
        acquire_sys("grant_a");
        run_tx("len3", 3, 3, 1'b1);
        sys_rel = 1'b1;
        tick();
        sys_rel = 1'b0;
        check("rel_after_done", outs(), 32'({6'b000011, buff_addr}));

        // Over-length request is clamped to one pass over the buffer.
        acquire_sys("grant_b");
        run_tx("len40", 40, 32, 1'b0);

        // Reset during TX_WAIT of the second byte.
        tx_go  = 1'b1;
        tx_len = 6'd3;
        tick();
        clear_inputs();
        tick();
        check("rst_seq_load1", 32'({tx_en, buff_addr}), 32'({1'b0, 5'd0}));
        tick();
        tick();
        tx_complete = 1'b1;
        tick();
        tx_complete = 1'b0;
        tick();
        check("rst_seq_load2", 32'({tx_en, buff_addr}), 32'({1'b0, 5'd1}));
        tick();
        check("rst_seq_wait2", 32'({busy, tx_en, buff_rd}), 32'(3'b111));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_abort", outs(), 32'({6'b000011, 5'd0}));
        for (int k = 0; k < 6; k++) begin
            tx_complete = (k % 2 == 0);
            tick();
            check($sformatf("post_rst_%0d", k), outs(), 32'({6'b000011, 5'd0}));
        end
        clear_inputs();

        // Normal transfer after the abort starts cleanly from address 0.
        acquire_sys("grant_c");
        run_tx("len2", 2, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buff_arbiter.md
BUFF_ARBITER -- requirements
Module: buff_arbiter

Interface
REQ-001 Parameter: WORDS, default 5, buffer address width (buffer depth 2^WORDS = 32 bytes).
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sys_req  input  1  System requests buffer ownership (level, held until granted).
REQ-005 sys_rel  input  1  System releases ownership (one-cycle pulse).
REQ-006 cli_req  input  1  Client requests buffer ownership (level, from RX signal decode).
REQ-007 cli_rel  input  1  Client releases ownership (one-cycle pulse, EOS handled).
REQ-008 sys_grant  output  1  System owns buffer.
REQ-009 cli_grant  output  1  Client owns buffer.
REQ-010 tx_go  input  1  System starts buffer transmission (pulse; honoured only while sys_grant=1).
REQ-011 tx_len  input  6  byte count to transmit, sampled on accepted tx_go.
REQ-012 buff_addr  output  WORDS  buffer read address.
REQ-013 buff_rd  output  1  buffer read strobe, active low.
REQ-014 tx_en  output  1  UART transmitter trigger, active low, one-cycle pulse.
REQ-015 tx_complete  input  1  transmitter byte-done, one-cycle pulse.
REQ-016 busy  output  1  transmission in progress.
REQ-017 done  output  1  one-cycle pulse at end of transmission.

Function
REQ-018 States SHALL be IDLE, SYS_OWN, CLI_OWN, TX_FETCH, TX_LOAD, TX_WAIT.
REQ-019 IDLE: cli_req=1 -> CLI_OWN; else sys_req=1 -> SYS_OWN; else stay; simultaneous requests -> Client wins.
REQ-020 Grant SHALL assert the cycle after the request is sampled in IDLE; sys_grant=1 exactly in SYS_OWN/TX_*, cli_grant=1 exactly in CLI_OWN; never both.
REQ-021 SYS_OWN: sys_rel -> IDLE; else accepted tx_go -> TX_FETCH with count=min(tx_len,32), buff_addr=0; tx_go with tx_len=0 -> done pulse next cycle, stay SYS_OWN.
REQ-022 CLI_OWN: cli_rel -> IDLE; tx_go ignored.
REQ-023 Requests from the non-owner SHALL stay pending and be served from IDLE after release; no preemption.
REQ-024 TX_FETCH: buff_rd=0 for one cycle at buff_addr -> TX_LOAD.
REQ-025 TX_LOAD: buff_rd=1, tx_en=0 for one cycle (data valid from synchronous read) -> TX_WAIT.
REQ-026 TX_WAIT: hold until tx_complete=1; then count-1; if count reaches 0 -> done=1 for one cycle, busy=0, SYS_OWN; else buff_addr+1 -> TX_FETCH.
REQ-027 buff_addr SHALL wrap 31->0 modulo 2^WORDS; count of 32 reads addresses 0..31 exactly once.
REQ-028 busy=1 in TX_FETCH, TX_LOAD, TX_WAIT only.
REQ-029 sys_rel, tx_go, and requests during TX_* SHALL be ignored (not queued); sys_grant held until done.
REQ-030 tx_complete outside TX_WAIT SHALL be ignored.
REQ-031 Per byte latency: tx_go accept -> first tx_en low = 2 cycles; tx_complete -> next tx_en low = 2 cycles.

Reset
REQ-032 reset=1 SHALL force IDLE next edge, including mid-transmission: sys_grant=0, cli_grant=0, buff_addr=0, buff_rd=1, tx_en=1, busy=0, done=0, count=0.
REQ-033 reset SHALL have priority over all inputs; no done pulse for an aborted transmission.

Verification
REQ-034 sys_req=1 and cli_req=1 same cycle from IDLE -> cli_grant=1 next cycle; after cli_rel, sys_grant=1 two cycles later.
REQ-035 SYS_OWN, tx_go with tx_len=3, tx_complete 5 cycles after each tx_en -> 3 tx_en pulses, buff_addr 0,1,2, done once, busy falls with done.
REQ-036 tx_len=40 -> exactly 32 tx_en pulses, buff_addr 0..31, then done.
REQ-037 tx_go with tx_len=0 -> no tx_en, done pulse next cycle; tx_go in CLI_OWN -> no response.
REQ-038 reset asserted in TX_WAIT of byte 2 -> next cycle all outputs at REQ-032 values, no done; later tx_complete ignored.
REQ-039 sys_rel during transmission -> ignored, sys_grant stays 1 until after done; subsequent sys_rel -> IDLE.
